// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register: one outstanding imem request,
// a one-entry stall buffer and an ID redirect. Optional perf counters under IF_STAGE_PERF_EN.
module if_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic [4:0]      if_id_rs1,
`ifdef IF_STAGE_PERF_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_kill_cnt,
`endif
    output logic [4:0]      if_id_rs2
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_kill;
    logic [XLEN-1:0] r_buf;
    logic            r_buf_valid;
    logic            r_if_id_valid;
    logic [XLEN-1:0] r_if_id_pc;
    logic [XLEN-1:0] r_if_id_instr;

    logic [XLEN-1:0] w_redirect_pc;
    logic            w_deliver_wait;
    logic            w_deliver_hold;
    logic            w_deliver;
    logic [XLEN-1:0] w_deliver_instr;
    logic            w_drop;

    assign w_redirect_pc   = redirect_pc & ~XLEN'(3);
    assign w_deliver_wait  = !redirect && (r_state == S_WAIT) && imem_rvalid && !r_kill && !stall;
    assign w_deliver_hold  = !redirect && (r_state == S_HOLD) && r_buf_valid && !stall;
    assign w_deliver       = w_deliver_wait || w_deliver_hold;
    assign w_deliver_instr = w_deliver_hold ? r_buf : imem_rdata;
    // A response is lost either to a pending kill or to a same-cycle redirect; a held buffer only to a redirect.
    assign w_drop          = ((r_state == S_WAIT) && imem_rvalid && (r_kill || redirect))
                          || ((r_state == S_HOLD) && redirect);

    assign imem_req    = (r_state == S_REQ) && !rst;
    assign imem_addr   = r_pc;
    assign if_id_valid = r_if_id_valid;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_rs1   = r_if_id_instr[19:15];
    assign if_id_rs2   = r_if_id_instr[24:20];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_buf         <= '0;
            r_buf_valid   <= 1'b0;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_INSTR;
        end else if (redirect) begin
            r_pc          <= w_redirect_pc;
            r_buf_valid   <= 1'b0;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= w_redirect_pc;
            r_if_id_instr <= NOP_INSTR;
            case (r_state)
                S_REQ: begin
                    if (imem_gnt) begin
                        r_state <= S_WAIT;
                        r_kill  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                        r_kill  <= 1'b0;
                    end else begin
                        r_kill  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                    r_kill  <= 1'b0;
                end
            endcase
        end else begin
            if (w_deliver) begin
                r_if_id_valid <= 1'b1;
                r_if_id_pc    <= r_pc;
                r_if_id_instr <= w_deliver_instr;
                r_pc          <= r_pc + XLEN'(4);
            end else if (!stall) begin
                r_if_id_valid <= 1'b0;
                r_if_id_pc    <= r_pc;
                r_if_id_instr <= NOP_INSTR;
            end
            case (r_state)
                S_REQ: begin
                    if (imem_gnt) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else if (stall) begin
                            r_buf       <= imem_rdata;
                            r_buf_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_buf_valid <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

`ifdef IF_STAGE_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
            r_perf_kill  <= '0;
        end else begin
            if (w_deliver && (r_perf_fetch != '1)) r_perf_fetch <= r_perf_fetch + 32'd1;
            if (stall && (r_perf_stall != '1))     r_perf_stall <= r_perf_stall + 32'd1;
            if (w_drop && (r_perf_kill != '1))     r_perf_kill  <= r_perf_kill + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
    assign perf_kill_cnt  = r_perf_kill;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule
